// File: rtl/jt900h_divn.sv
// Restoring divider for the 900H core: 2*DW/DW (full) or DW/(DW/2) (half),
// signed or unsigned, one quotient bit per enabled clock, with abort and
// divide-by-zero handling.
module jt900h_divn #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [2*DW-1:0] op0,
  input  logic [DW-1:0] op1,
  input  logic          len,
  input  logic          sign,
  input  logic          start,
  input  logic          abort,
  output logic [DW-1:0] quot,
  output logic [DW-1:0] rem,
  output logic          busy,
  output logic          done,
  output logic          v
);

  localparam int HW = DW / 2;
  localparam int CW = $clog2(2 * DW) + 1;

  // Narrow a DW-bit result to half width: upper half is a sign copy or zero.
  function automatic logic [DW-1:0] fit(input logic [DW-1:0] x, input logic half,
                                        input logic sx);
    logic [DW-1:0] y;
    y = x;
    if (half) y[DW-1:HW] = sx ? {HW{x[HW-1]}} : '0;
    return y;
  endfunction

  // Quotient magnitude outside the representable range of the result width.
  function automatic logic ovf(input logic [2*DW-1:0] qm, input logic half,
                               input logic sg, input logic neg);
    logic [2*DW-1:0] lim;
    logic [2*DW-1:0] lim_h;
    logic            o;
    lim   = {{(2*DW-1){1'b0}}, 1'b1} << (half ? HW : DW);
    lim_h = lim >> 1;
    if (!sg)      o = (qm >= lim);
    else if (neg) o = (qm > lim_h);
    else          o = (qm >= lim_h);
    return o;
  endfunction

  logic          start_l_q, start_l_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          v_q, v_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*DW-1:0] sh_q, sh_d;
  logic [DW-1:0] rm_q, rm_d;
  logic [DW-1:0] dv_q, dv_d;
  logic          len_q, len_d;
  logic          sgn_q, sgn_d;
  logic          nq_q, nq_d;
  logic          nr_q, nr_d;
  logic          dz_q, dz_d;

  logic            a_sgn, b_sgn, dz_in;
  logic [2*DW-1:0] a_ext, a_mag;
  logic [DW-1:0]   b_ext, b_mag;

  // Operand selection and conversion to magnitude at start time.
  always_comb begin
    a_sgn = sign & (len ? op0[2*DW-1] : op0[DW-1]);
    b_sgn = sign & (len ? op1[DW-1] : op1[HW-1]);
    if (len)       a_ext = op0;
    else if (sign) a_ext = {{DW{op0[DW-1]}}, op0[DW-1:0]};
    else           a_ext = {{DW{1'b0}}, op0[DW-1:0]};
    b_ext = len ? op1 : fit(op1, 1'b1, sign);
    a_mag = a_sgn ? -a_ext : a_ext;
    b_mag = b_sgn ? -b_ext : b_ext;
    dz_in = len ? (op1 == '0) : (op1[HW-1:0] == '0);
  end

  logic [DW:0]     rm_sh, diff;
  logic            ge;
  logic [DW-1:0]   rm_nx;
  logic [2*DW-1:0] sh_nx, qm;
  logic [DW-1:0]   q_lo, r_lo, quot_nx, rem_nx;
  logic            v_nx;

  // One restoring step plus the sign/width fix-up applied on the last step.
  always_comb begin
    rm_sh   = {rm_q, sh_q[2*DW-1]};
    diff    = rm_sh - {1'b0, dv_q};
    ge      = ~diff[DW];
    rm_nx   = ge ? diff[DW-1:0] : rm_sh[DW-1:0];
    sh_nx   = {sh_q[2*DW-2:0], ge};
    qm      = len_q ? sh_nx : {{DW{1'b0}}, sh_nx[DW-1:0]};
    q_lo    = nq_q ? -qm[DW-1:0] : qm[DW-1:0];
    r_lo    = nr_q ? -rm_nx : rm_nx;
    quot_nx = fit(q_lo, ~len_q, sgn_q);
    rem_nx  = fit(r_lo, ~len_q, sgn_q);
    v_nx    = ovf(qm, ~len_q, sgn_q, nq_q);
  end

  // Control: start edge detection, iteration count, completion and abort.
  always_comb begin
    start_l_d = start_l_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    v_d       = v_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rm_d      = rm_q;
    dv_d      = dv_q;
    len_d     = len_q;
    sgn_d     = sgn_q;
    nq_d      = nq_q;
    nr_d      = nr_q;
    dz_d      = dz_q;
    if (cen) start_l_d = start;
    if (busy_q) begin
      if (abort) begin
        busy_d = 1'b0;
      end else if (cen) begin
        if (dz_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          v_d    = 1'b1;
          quot_d = '1;
          rem_d  = rm_q;
        end else begin
          sh_d  = sh_nx;
          rm_d  = rm_nx;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            v_d    = v_nx;
            quot_d = quot_nx;
            rem_d  = rem_nx;
          end
        end
      end
    end else if (cen && start && !start_l_q && !abort) begin
      busy_d = 1'b1;
      len_d  = len;
      sgn_d  = sign;
      nq_d   = a_sgn ^ b_sgn;
      nr_d   = a_sgn;
      dz_d   = dz_in;
      dv_d   = b_mag;
      sh_d   = len ? a_mag : {a_mag[DW-1:0], {DW{1'b0}}};
      rm_d   = dz_in ? fit(op0[DW-1:0], ~len, sign) : '0;
      cnt_d  = len ? CW'(2 * DW) : CW'(DW);
    end
  end

  // State registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_l_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      v_q       <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      rm_q      <= '0;
      dv_q      <= '0;
      len_q     <= 1'b0;
      sgn_q     <= 1'b0;
      nq_q      <= 1'b0;
      nr_q      <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      start_l_q <= start_l_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      v_q       <= v_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rm_q      <= rm_d;
      dv_q      <= dv_d;
      len_q     <= len_d;
      sgn_q     <= sgn_d;
      nq_q      <= nq_d;
      nr_q      <= nr_d;
      dz_q      <= dz_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign busy = busy_q;
  assign done = done_q;
  assign v    = v_q;

endmodule

// File: tb/tb_jt900h_divn.sv
// Bench for jt900h_divn (DW=16): directed vectors, random operations against
// an integer-arithmetic reference, abort, start qualification, cen gating, reset.
module tb_jt900h_divn;

  logic        clk;
  logic        rst;
  logic        cen;
  logic [31:0] op0;
  logic [15:0] op1;
  logic        len;
  logic        sign;
  logic        start;
  logic        abort;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        busy;
  logic        done;
  logic        v;

  int nchk = 0;
  int nerr = 0;

  logic [15:0] last_q, last_r;
  logic        last_v;

  jt900h_divn #(.DW(16)) dut (
    .clk(clk), .rst(rst), .cen(cen), .op0(op0), .op1(op1), .len(len),
    .sign(sign), .start(start), .abort(abort), .quot(quot), .rem(rem),
    .busy(busy), .done(done), .v(v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ext(input logic [15:0] x, input logic ln, input logic sg);
    logic [15:0] y;
    if (ln)      y = x;
    else if (sg) y = {{8{x[7]}}, x[7:0]};
    else         y = {8'h00, x[7:0]};
    return y;
  endfunction

  // Truncating division on plain integers, results narrowed to the mode width.
  function automatic void model(input logic [31:0] a0, input logic [15:0] b0,
                                input logic ln, input logic sg,
                                output logic [15:0] eq, output logic [15:0] er,
                                output logic ev);
    longint a, b, q, r, lim;
    logic [15:0] a16;
    logic [7:0]  b8;
    a16 = a0[15:0];
    b8  = b0[7:0];
    if (ln) a = sg ? longint'($signed(a0)) : longint'(a0);
    else    a = sg ? longint'($signed(a16)) : longint'(a16);
    if (ln) b = sg ? longint'($signed(b0)) : longint'(b0);
    else    b = sg ? longint'($signed(b8)) : longint'(b8);
    lim = ln ? 65536 : 256;
    if (b == 0) begin
      ev = 1'b1;
      eq = 16'hFFFF;
      er = ext(a16, ln, sg);
    end else begin
      q = a / b;
      r = a % b;
      if (sg) ev = (q > lim / 2 - 1) || (q < -(lim / 2));
      else    ev = (q >= lim);
      eq = ext(16'(q), ln, sg);
      er = ext(16'(r), ln, sg);
    end
  endfunction

  task automatic launch(input logic [31:0] a, input logic [15:0] b,
                        input logic ln, input logic sg, input string tag);
    @(negedge clk);
    op0 = a; op1 = b; len = ln; sign = sg;
    start = 1'b1; cen = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input logic hold, input logic tog, input int exp_lat,
                           input string tag, input logic [15:0] eq,
                           input logic [15:0] er, input logic ev);
    int   lat;
    logic seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (tog) cen = ~cen;
      @(posedge clk); #1;
      lat++;
      seen = done;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_quot"}, 32'(quot), 32'(eq));
    chk({tag, "_rem"}, 32'(rem), 32'(er));
    chk({tag, "_v"}, 32'(v), 32'(ev));
    @(negedge clk);
    if (tog) cen = ~cen;
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    last_q = eq; last_r = er; last_v = ev;
  endtask

  initial begin
    logic [31:0] ra;
    logic [15:0] rb, eq, er;
    logic        rl, rs, ev, any_done;
    int          lat;

    rst = 1'b1; cen = 1'b0; start = 1'b0; abort = 1'b0;
    op0 = '0; op1 = '0; len = 1'b0; sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_v", 32'(v), 32'd0);
    @(negedge clk);
    rst = 1'b0; cen = 1'b1;
    @(posedge clk);

    // Directed vectors
    launch(32'h0001_0000, 16'h0003, 1'b1, 1'b0, "ufull");
    wait_done(1'b0, 1'b0, 32, "ufull", 16'h5555, 16'h0001, 1'b0);
    launch(32'h0000_FFF9, 16'h0002, 1'b0, 1'b1, "shalf");
    wait_done(1'b0, 1'b0, 16, "shalf", 16'hFFFD, 16'hFFFF, 1'b0);
    launch(32'h1234_5678, 16'h0000, 1'b1, 1'b0, "dz");
    wait_done(1'b0, 1'b0, 1, "dz", 16'hFFFF, 16'h5678, 1'b1);
    launch(32'h0002_0000, 16'h0001, 1'b1, 1'b0, "ovfu");
    wait_done(1'b0, 1'b0, 32, "ovfu", 16'h0000, 16'h0000, 1'b1);
    launch(32'hFFFF_8000, 16'hFFFF, 1'b1, 1'b1, "ovfs");
    wait_done(1'b0, 1'b0, 32, "ovfs", 16'h8000, 16'h0000, 1'b1);

    // Random operations
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = 16'($urandom);
      rl = 1'($urandom);
      rs = 1'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 16'h0000;
        1: ra = {{8{ra[31]}}, ra[31:8]} >> ($urandom_range(4, 12));
        2: ra = rl ? {{12{ra[19]}}, ra[19:0]} : {16'h0000, {6{ra[9]}}, ra[9:0]};
        default: ;
      endcase
      model(ra, rb, rl, rs, eq, er, ev);
      lat = ((rl ? rb : {8'h00, rb[7:0]}) == 16'h0000) ? 1 : (rl ? 32 : 16);
      launch(ra, rb, rl, rs, "rnd");
      wait_done(1'b0, 1'b0, lat, $sformatf("rnd%0d", i), eq, er, ev);
    end

    // Abort after 5 iterations, with cen low on the abort edge
    launch(32'h0000_0064, 16'h0007, 1'b1, 1'b0, "abt");
    repeat (5) begin
      @(negedge clk); start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    abort = 1'b1; cen = 1'b0;
    @(posedge clk); #1;
    chk("abt_busy", 32'(busy), 32'd0);
    chk("abt_done", 32'(done), 32'd0);
    chk("abt_quot", 32'(quot), 32'(last_q));
    chk("abt_rem", 32'(rem), 32'(last_r));
    chk("abt_v", 32'(v), 32'(last_v));
    @(negedge clk);
    abort = 1'b0; cen = 1'b1;
    any_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) any_done = 1'b1;
    end
    chk("abt_nodone", 32'(any_done), 32'd0);
    launch(32'h0000_0064, 16'h0007, 1'b1, 1'b0, "after_abt");
    wait_done(1'b0, 1'b0, 32, "after_abt", 16'd14, 16'd2, 1'b0);

    // Start rising edge while busy is ignored
    launch(32'h0000_03E8, 16'h0009, 1'b1, 1'b0, "rebusy");
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b1; op0 = 32'hFFFF_FFFF; op1 = 16'h0001;
    @(posedge clk); #1;
    wait_done(1'b0, 1'b0, 30, "rebusy", 16'd111, 16'd1, 1'b0);

    // Abort on the same edge as a start edge: abort wins, edge consumed
    @(negedge clk);
    op0 = 32'h0000_0100; op1 = 16'h0002; len = 1'b1; sign = 1'b0;
    start = 1'b1; abort = 1'b1; cen = 1'b1;
    @(posedge clk); #1;
    chk("abtstart_busy", 32'(busy), 32'd0);
    @(negedge clk); abort = 1'b0;
    @(posedge clk); #1;
    chk("abtstart_consumed", 32'(busy), 32'd0);
    @(negedge clk); start = 1'b0;
    @(posedge clk);

    // cen toggling with start held high
    launch(32'h0001_0000, 16'h0003, 1'b1, 1'b0, "cen");
    wait_done(1'b1, 1'b1, 64, "cen", 16'h5555, 16'h0001, 1'b0);
    @(negedge clk); cen = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("cen_noretrig", 32'(busy), 32'd0);
    @(negedge clk); start = 1'b0;
    @(posedge clk);

    // Reset mid-operation, then start held through reset release
    launch(32'h0001_0000, 16'h0003, 1'b1, 1'b0, "rstop");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; cen = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("midrst_quot", 32'(quot), 32'd0);
    chk("midrst_rem", 32'(rem), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_v", 32'(v), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; cen = 1'b1;
    @(posedge clk); #1;
    chk("rel_busy", 32'(busy), 32'd1);
    wait_done(1'b0, 1'b0, 32, "rel", 16'h5555, 16'h0001, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
